// File: rtl/video_timing_gen.sv
// Raster timing generator: hs/vs/de, pixel coordinates and frame/line strobes, start/stop on frame boundaries.
// Optional feature: define VTG_TESTPATTERN_EN for a built-in 8-bar colour source on red/green/blue.
module video_timing_gen #(
  parameter int   H_SYNC     = 128,
  parameter int   H_BP       = 128,
  parameter int   H_ACTIVE   = 800,
  parameter int   H_FP       = 32,
  parameter int   V_SYNC     = 4,
  parameter int   V_BP       = 14,
  parameter int   V_ACTIVE   = 600,
  parameter int   V_FP       = 1,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   CNT_W      = 12,
  parameter int   COORD_W    = 11
) (
  input  logic               pixelClk,
  input  logic               reset,
  input  logic               enable,
  output logic               stopped,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [COORD_W-1:0] pixelX,
  output logic [COORD_W-1:0] pixelY,
  output logic               frameStart,
  output logic               lineStart,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  if (H_TOTAL > (1 << CNT_W)) begin : g_h_total_chk
    $error("video_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_v_total_chk
    $error("video_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (H_ACTIVE > (1 << COORD_W)) begin : g_h_coord_chk
    $error("video_timing_gen: H_ACTIVE does not fit in COORD_W bits");
  end
  if (V_ACTIVE > (1 << COORD_W)) begin : g_v_coord_chk
    $error("video_timing_gen: V_ACTIVE does not fit in COORD_W bits");
  end

  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;
  logic             h_act;
  logic             v_act;
  logic             pix_act;

  assign h_last  = (h_cnt == H_LAST);
  assign v_last  = (v_cnt == V_LAST);
  assign h_act   = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
  assign v_act   = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
  assign pix_act = h_act && v_act;

  // stopped is the FSM state itself, so it tracks IDLE exactly.
  assign stopped = (state == ST_IDLE);

  // Frame-boundary FSM: enable is only honoured in IDLE and at the last pixel of a frame.
  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
              v_cnt <= '0;
              if (!enable) state <= ST_IDLE;
            end else begin
              v_cnt <= v_cnt + CNT_W'(1);
            end
          end else begin
            h_cnt <= h_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          h_cnt <= '0;
          v_cnt <= '0;
        end
      endcase
    end
  end

  // Timing outputs are registered from the current counters, one cycle behind them.
  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      hs         <= ~H_SYNC_POL;
      vs         <= ~V_SYNC_POL;
      de         <= 1'b0;
      pixelX     <= '0;
      pixelY     <= '0;
      frameStart <= 1'b0;
      lineStart  <= 1'b0;
    end else if (state == ST_RUN) begin
      hs         <= (h_cnt < H_SYNC_END) ? H_SYNC_POL : ~H_SYNC_POL;
      vs         <= (v_cnt < V_SYNC_END) ? V_SYNC_POL : ~V_SYNC_POL;
      de         <= pix_act;
      pixelX     <= pix_act ? COORD_W'(h_cnt - H_ACT_BEG) : '0;
      pixelY     <= pix_act ? COORD_W'(v_cnt - V_ACT_BEG) : '0;
      frameStart <= (h_cnt == '0) && (v_cnt == '0);
      lineStart  <= (h_cnt == '0);
    end else begin
      hs         <= ~H_SYNC_POL;
      vs         <= ~V_SYNC_POL;
      de         <= 1'b0;
      pixelX     <= '0;
      pixelY     <= '0;
      frameStart <= 1'b0;
      lineStart  <= 1'b0;
    end
  end

`ifdef VTG_TESTPATTERN_EN
  localparam int               BAR_W    = ((H_ACTIVE >> 3) > 0) ? (H_ACTIVE >> 3) : 1;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] bar_pix;
  logic [2:0]       bar_idx;

  // bar_idx/bar_pix describe the pixel currently in h_cnt; they restart every line.
  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if ((state != ST_RUN) || h_last) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (h_act) begin
      if (bar_pix == BAR_LAST) begin
        bar_pix <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pix <= bar_pix + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      red   <= 8'h00;
      green <= 8'h00;
      blue  <= 8'h00;
    end else if ((state == ST_RUN) && pix_act) begin
      red   <= {8{~bar_idx[1]}};
      green <= {8{~bar_idx[2]}};
      blue  <= {8{~bar_idx[0]}};
    end else begin
      red   <= 8'h00;
      green <= 8'h00;
      blue  <= 8'h00;
    end
  end
`else
  assign red   = 8'h00;
  assign green = 8'h00;
  assign blue  = 8'h00;
`endif

endmodule
